rs232_hex_format: RTL and testbench



---
 rtl/rs232_hex_format_pkg.sv | 22 ++
 rtl/hex_nibble_to_ascii.sv | 17 +
 rtl/rs232_hex_format.sv | 95 +++++++++
 tb/tb_rs232_hex_format.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_hex_format_pkg.sv
// Shared definitions for the RS232 hex formatter: ASCII constants, FSM encoding
// and the index-width helper.
package rs232_hex_format_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    IDLE,
    HEX,
    CR,
    LF
  } fmt_state_t;

  // A single-nibble word still needs a one-bit index register.
  function automatic int index_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit converter, shared with the
// dump/monitor blocks.
module hex_nibble_to_ascii
  import rs232_hex_format_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_0 + {4'h0, nibble};
    if (nibble > 4'd9) begin
      ascii = ASCII_A + {4'h0, nibble - 4'd10};
    end
  end

endmodule

// File: rtl/rs232_hex_format.sv
// Formats binary words as uppercase ASCII hex (MS nibble first, optional CR LF)
// and streams the characters one byte at a time toward the RS232 transmitter.
module rs232_hex_format
  import rs232_hex_format_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter bit NEWLINE    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int NIBBLES = WORD_WIDTH / 4;
  localparam int IDX_W   = index_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  fmt_state_t            state;
  logic [IDX_W-1:0]      index;
  logic [WORD_WIDTH-1:0] shift;
  logic [3:0]            nibble;
  logic [7:0]            digit;
  logic                  transfer;

  // On accept the top digit comes straight from in_data, so the shift register
  // only ever holds the digits that are still to be sent.
  assign nibble   = (state == IDLE) ? in_data[WORD_WIDTH-1 -: 4] : shift[WORD_WIDTH-1 -: 4];
  assign transfer = out_valid && out_ready;

  hex_nibble_to_ascii u_conv (
    .nibble (nibble),
    .ascii  (digit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      index     <= '0;
      shift     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            shift     <= in_data << 4;
            index     <= LAST_IDX;
            out_data  <= digit;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= HEX;
          end
        end
        HEX: begin
          if (transfer) begin
            if (index != '0) begin
              index    <= index - 1'b1;
              out_data <= digit;
              shift    <= shift << 4;
            end else if (NEWLINE) begin
              out_data <= ASCII_CR;
              state    <= CR;
            end else begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        CR: begin
          if (transfer) begin
            out_data <= ASCII_LF;
            state    <= LF;
          end
        end
        LF: begin
          if (transfer) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_hex_format.sv
// Self-checking bench for rs232_hex_format: a 32-bit CR/LF instance and an
// 8-bit digits-only instance, compared against a queue-based reference model.
module tb_rs232_hex_format;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  logic [7:0]  in_data8;
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  out_data8;
  logic        out_valid8;
  logic        out_ready8;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  rs232_hex_format #(.WORD_WIDTH(32), .NEWLINE(1'b1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  rs232_hex_format #(.WORD_WIDTH(8), .NEWLINE(1'b0)) dut8 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .out_data  (out_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8)
  );

  function automatic logic [7:0] hex_char(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Reference model: the full character stream a word should produce.
  function automatic void build_expected(input logic [31:0] word, input int nibbles, input bit newline);
    exp_q.delete();
    for (int i = nibbles - 1; i >= 0; i--) begin
      exp_q.push_back(hex_char(int'((word >> (4 * i)) & 32'hF)));
    end
    if (newline) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns after the negedge that precedes the accepting edge.
  task automatic applyStimulus(input logic [31:0] word);
    int waited;
    in_data  = word;
    in_valid = 1'b1;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    if (in_ready !== 1'b1) checkOutput("accept_timeout", 32'd0, 32'd1);
    build_expected(word, 8, 1'b1);
  endtask

  // Drains the expected characters; all_ready=0 toggles out_ready randomly,
  // hold=1 keeps in_valid high with garbage data during emission.
  task automatic collectBytes(input bit all_ready, input bit hold);
    int idx;
    int cyc;
    int n;
    bit prev_stall;
    logic [7:0] prev_data;
    idx = 0;
    n = exp_q.size();
    prev_stall = 1'b0;
    prev_data = 8'h00;
    @(negedge clock);
    in_valid = hold;
    checkOutput("first_digit_latency", {31'd0, out_valid}, 32'd1);
    for (cyc = 0; cyc < 400 && idx < n; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (hold) in_data = $urandom;
      if (prev_stall) begin
        checkOutput("stall_valid_hold", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_data_hold", {24'd0, out_data}, {24'd0, prev_data});
      end
      out_ready = all_ready ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        checkOutput($sformatf("byte%0d", idx), {24'd0, out_data}, {24'd0, exp_q[idx]});
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = out_valid && !out_ready;
      end
      prev_data = out_data;
    end
    if (idx < n) checkOutput("drain_timeout", idx, n);
    if (all_ready) checkOutput("no_bubble_cycles", cyc, n);
    @(negedge clock);
    out_ready = 1'b1;
    checkOutput("idle_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    reset_n    = 1'b0;
    in_data    = 32'h0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_data8   = 8'h0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_data", {24'd0, out_data}, 32'd0);
    in_data = 32'hxxxx_xxxx;
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    checkOutput("x_data_no_output", {31'd0, out_valid}, 32'd0);

    $display("[TB] word 0x0123ABCD, out_ready high");
    applyStimulus(32'h0123ABCD);
    collectBytes(1'b1, 1'b0);

    $display("[TB] word 0x0123ABCD, out_ready random");
    applyStimulus(32'h0123ABCD);
    collectBytes(1'b0, 1'b0);

    $display("[TB] boundary words");
    applyStimulus(32'h0000_0000);
    collectBytes(1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFFF);
    collectBytes(1'b0, 1'b0);

    $display("[TB] random words");
    for (int k = 0; k < 6; k++) begin
      w = $urandom;
      applyStimulus(w);
      collectBytes(k[0], 1'b0);
    end

    $display("[TB] in_valid held with changing data");
    applyStimulus(32'h89ABCDEF);
    collectBytes(1'b1, 1'b1);
    applyStimulus(32'h7654_3210);
    collectBytes(1'b1, 1'b0);

    $display("[TB] reset mid-word");
    applyStimulus(32'h13579BDF);
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("pre_reset_d0", {24'd0, out_data}, {24'd0, exp_q[0]});
    @(negedge clock);
    checkOutput("pre_reset_d1", {24'd0, out_data}, {24'd0, exp_q[1]});
    @(negedge clock);
    checkOutput("pre_reset_d2", {24'd0, out_data}, {24'd0, exp_q[2]});
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    checkOutput("abort_in_ready_rise", {31'd0, in_ready}, 32'd1);
    checkOutput("abort_no_leftover", {31'd0, out_valid}, 32'd0);
    applyStimulus(32'hDEADBEEF);
    collectBytes(1'b1, 1'b0);

    $display("[TB] 8-bit digits-only back-to-back");
    in_data8  = 8'h00;
    in_valid8 = 1'b1;
    for (int t = 0; t < 40 && in_ready8 !== 1'b1; t++) @(negedge clock);
    if (in_ready8 !== 1'b1) checkOutput("accept8_timeout", 32'd0, 32'd1);
    @(negedge clock);
    in_data8 = 8'hFF;
    checkOutput("b2b_d0_valid", {31'd0, out_valid8}, 32'd1);
    checkOutput("b2b_d0", {24'd0, out_data8}, {24'd0, hex_char(0)});
    @(negedge clock);
    checkOutput("b2b_d1", {24'd0, out_data8}, {24'd0, hex_char(0)});
    @(negedge clock);
    checkOutput("b2b_idle_valid", {31'd0, out_valid8}, 32'd0);
    checkOutput("b2b_idle_ready", {31'd0, in_ready8}, 32'd1);
    @(negedge clock);
    in_valid8 = 1'b0;
    checkOutput("b2b_d2_valid", {31'd0, out_valid8}, 32'd1);
    checkOutput("b2b_d2", {24'd0, out_data8}, {24'd0, hex_char(15)});
    @(negedge clock);
    checkOutput("b2b_d3", {24'd0, out_data8}, {24'd0, hex_char(15)});
    @(negedge clock);
    checkOutput("b2b_end_valid", {31'd0, out_valid8}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
